// File: rtl/scan_addr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scan_addr_pkg
//  Purpose  : Shared definitions for the scan address generator: the
//             controller state encoding and the default parameter widths.
//  Revision : 1.0 - initial release
// ============================================================================
package scan_addr_pkg;

    localparam int c_default_addr_w  = 5;
    localparam int c_default_dwell_w = 16;
    localparam int c_default_wrap_w  = 8;

    // Encoding is fixed; the unused code 2'd3 is treated as illegal and
    // recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage : scan_addr_pkg
`default_nettype wire

// File: rtl/scan_next_unmasked.sv
`default_nettype none
// ============================================================================
//  Module   : scan_next_unmasked
//  Purpose  : Combinational search for the lowest set bit of i_bits whose
//             index is at or above i_from. Used with the inverted skip mask
//             so a set bit means "address may be presented".
//  Ports    : i_bits  [2^ADDR_W-1:0]  candidate vector (1 = eligible)
//             i_from  [ADDR_W:0]      lowest index to consider; one bit wider
//                                     than an address so "past the top"
//                                     (2^ADDR_W) is representable
//             o_idx   [ADDR_W-1:0]    index found (0 when none)
//             o_found                 an eligible bit exists at/above i_from
//  Revision : 1.0 - initial release
// ============================================================================
module scan_next_unmasked #(
    parameter int ADDR_W = 5
) (
    input  logic [(1<<ADDR_W)-1:0] i_bits,
    input  logic [ADDR_W:0]        i_from,
    output logic [ADDR_W-1:0]      o_idx,
    output logic                   o_found
);

    // Scan downward so the lowest qualifying index is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = (1 << ADDR_W) - 1; i >= 0; i--) begin
            if (i_bits[i] && (i >= int'(i_from))) begin
                o_idx   = ADDR_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule : scan_next_unmasked
`default_nettype wire

// File: rtl/scan_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : scan_addr_gen
//  Purpose  : Sequential address sweeper feeding an N-to-2^N decoder select.
//             Steps addr_out from the first to the last address, holding each
//             for a programmable dwell, with a valid/ready handshake. Supports
//             single-sweep and continuous-wrap modes.
//  Ports    : clk, rst          clock, synchronous active-high reset
//             start, stop       sweep request (IDLE only) / abort (SCAN)
//             cont, dwell       mode and per-address dwell, sampled with start
//             ready             consumer accepts the current address
//             addr_out          current address
//             addr_valid, busy  high while sweeping
//             done              one-cycle pulse at the end of a single sweep
//             wrap_cnt          saturating count of completed wraps
//             skip_mask         (optional) 1 = address is never presented
//  Options  : define SCAN_ADDR_GEN_SKIP_MASK_EN to add skip_mask
//  Revision : 1.0 - initial release
// ============================================================================
module scan_addr_gen
    import scan_addr_pkg::*;
#(
    parameter int ADDR_W  = c_default_addr_w,
    parameter int DWELL_W = c_default_dwell_w,
    parameter int WRAP_W  = c_default_wrap_w
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   cont,
    input  logic [DWELL_W-1:0]     dwell,
    input  logic                   ready,
`ifdef SCAN_ADDR_GEN_SKIP_MASK_EN
    input  logic [(1<<ADDR_W)-1:0] skip_mask,
`endif
    output logic [ADDR_W-1:0]      addr_out,
    output logic                   addr_valid,
    output logic                   busy,
    output logic                   done,
    output logic [WRAP_W-1:0]      wrap_cnt
);

    scan_state_e          r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic [WRAP_W-1:0]    r_wrap;
    logic [DWELL_W-1:0]   r_dwell_cnt;
    logic [DWELL_W-1:0]   r_dwell;
    logic                 r_cont;

    // First address of a sweep and the address following r_addr.
    // *_found low means "no such address" (all masked / end of sweep).
    logic [ADDR_W-1:0]    w_first_addr;
    logic                 w_first_found;
    logic [ADDR_W-1:0]    w_next_addr;
    logic                 w_next_found;
    logic                 w_launch;

    assign w_launch = (r_state == ST_IDLE) && start && !stop;

`ifdef SCAN_ADDR_GEN_SKIP_MASK_EN
    logic [(1<<ADDR_W)-1:0] r_skip_mask;
    logic [(1<<ADDR_W)-1:0] w_first_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip_mask <= '0;
        end else if (w_launch) begin
            r_skip_mask <= skip_mask;
        end
    end

    // In IDLE the first address comes from the live port (it is being
    // latched this edge); once sweeping, wraps use the latched copy.
    assign w_first_src = (r_state == ST_IDLE) ? ~skip_mask : ~r_skip_mask;

    scan_next_unmasked #(
        .ADDR_W (ADDR_W)
    ) u_first (
        .i_bits  (w_first_src),
        .i_from  ('0),
        .o_idx   (w_first_addr),
        .o_found (w_first_found)
    );

    scan_next_unmasked #(
        .ADDR_W (ADDR_W)
    ) u_next (
        .i_bits  (~r_skip_mask),
        .i_from  ({1'b0, r_addr} + (ADDR_W+1)'(1)),
        .o_idx   (w_next_addr),
        .o_found (w_next_found)
    );
`else
    assign w_first_addr  = '0;
    assign w_first_found = 1'b1;
    assign w_next_addr   = r_addr + ADDR_W'(1);
    assign w_next_found  = ~&r_addr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wrap      <= '0;
            r_dwell_cnt <= '0;
            r_dwell     <= '0;
            r_cont      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_cont <= cont;
                        r_dwell <= dwell;
                        r_wrap <= '0;
                        if (w_first_found) begin
                            r_state     <= ST_SCAN;
                            r_addr      <= w_first_addr;
                            r_dwell_cnt <= dwell;
                            r_valid     <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            // Nothing to present: finish immediately.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_SCAN: begin
                    if (stop) begin
                        // Abort wins over any advance; address holds.
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_dwell_cnt != '0) begin
                        // Dwell runs down independent of ready.
                        r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                    end else if (ready) begin
                        if (w_next_found) begin
                            r_addr      <= w_next_addr;
                            r_dwell_cnt <= r_dwell;
                        end else if (r_cont) begin
                            r_addr      <= w_first_addr;
                            r_dwell_cnt <= r_dwell;
                            if (r_wrap != '1) begin
                                r_wrap <= r_wrap + WRAP_W'(1);
                            end
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_out   = r_addr;
    assign addr_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign wrap_cnt   = r_wrap;

endmodule : scan_addr_gen
`default_nettype wire

// File: tb/tb_scan_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_addr_gen
//  Purpose  : Self-checking bench for scan_addr_gen (ADDR_W=3, WRAP_W=2).
//             A sweep-level reference model predicts every output each cycle;
//             directed scenarios add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scan_addr_gen;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int WW = 2;
    localparam int LAST_ADDR = (1 << AW) - 1;
    localparam int WRAP_MAX  = (1 << WW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          cont;
    logic [DW-1:0] dwell;
    logic          ready;
    logic [AW-1:0] addr_out;
    logic          addr_valid;
    logic          busy;
    logic          done;
    logic [WW-1:0] wrap_cnt;
`ifdef SCAN_ADDR_GEN_SKIP_MASK_EN
    logic [(1<<AW)-1:0] skip_mask = '0;
`endif

    scan_addr_gen #(
        .ADDR_W  (AW),
        .DWELL_W (DW),
        .WRAP_W  (WW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .dwell      (dwell),
        .ready      (ready),
`ifdef SCAN_ADDR_GEN_SKIP_MASK_EN
        .skip_mask  (skip_mask),
`endif
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .busy       (busy),
        .done       (done),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: mode 0 = idle, 1 = sweeping, 2 = reporting completion.
    // m_age counts cycles the current address has been shown; an address may
    // be accepted once it has been shown for more than 'dwell' cycles.
    int m_mode  = 0;
    int m_addr  = 0;
    int m_age   = 0;
    int m_dwell = 0;
    int m_wraps = 0;
    bit m_cont  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_mode = 0; m_addr = 0; m_age = 0; m_wraps = 0;
        end else begin
            case (m_mode)
                0: if (start && !stop) begin
                    m_mode = 1; m_addr = 0; m_age = 0; m_wraps = 0;
                    m_cont = cont; m_dwell = int'(dwell);
                end
                1: if (stop) begin
                    m_mode = 0;
                end else if (m_age >= m_dwell && ready) begin
                    m_age = 0;
                    if (m_addr < LAST_ADDR) m_addr = m_addr + 1;
                    else if (m_cont) begin m_addr = 0; m_wraps = m_wraps + 1; end
                    else m_mode = 2;
                end else begin
                    m_age = m_age + 1;
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("addr_out",   addr_out,   m_addr);
            chk("addr_valid", addr_valid, m_mode == 1);
            chk("busy",       busy,       m_mode == 1);
            chk("done",       done,       m_mode == 2);
            chk("wrap_cnt",   wrap_cnt,   (m_wraps > WRAP_MAX) ? WRAP_MAX : m_wraps);
        end
    end

    // Apply one cycle of inputs, advance the model on the edge, and return
    // just after the following falling edge (after the compare has run).
    task automatic step(input bit r, input bit s, input bit p, input bit c,
                        input int d, input bit rd);
        rst = r; start = s; stop = p; cont = c; dwell = DW'(d); ready = rd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int dones;

        step(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        chk("reset_valid", addr_valid, 0);
        chk("reset_addr",  addr_out,   0);
        chk("reset_wrap",  wrap_cnt,   0);

        // Single sweep, dwell 0, ready held high.
        step(0, 1, 0, 0, 0, 1);
        chk("t1_first_addr",  addr_out,   0);
        chk("t1_first_valid", addr_valid, 1);
        for (int i = 1; i <= LAST_ADDR; i++) begin
            step(0, 0, 0, 0, 0, 1);
            chk("t1_seq_addr", addr_out, i);
        end
        step(0, 0, 0, 0, 0, 1);
        chk("t1_done",      done,       1);
        chk("t1_done_addr", addr_out,   7);
        chk("t1_done_vld",  addr_valid, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("t1_done_once", done, 0);

        // Dwell 2: three cycles per address; dwell/cont wiggled mid-sweep.
        step(0, 1, 0, 0, 2, 1);
        cnt = addr_valid ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0, (i % 2) == 1, 5, 1);
            if (addr_valid) cnt++;
            else break;
        end
        chk("t2_valid_cycles", cnt, 24);
        step(0, 0, 0, 0, 0, 0);

        // Ready pattern 1,0,0,1 with dwell 0.
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("t3_after_r1", addr_out, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_hold", addr_out, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t3_after_r4", addr_out, 2);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Continuous mode, 40 accepts: five wraps, counter saturates at 3.
        step(0, 1, 0, 1, 0, 0);
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            step(0, 0, 0, 0, 0, 1);
            if (done) dones++;
            if (k == 8) begin
                chk("t4_wrap_addr", addr_out, 0);
                chk("t4_wrap1",     wrap_cnt, 1);
            end
        end
        chk("t4_wrap_sat", wrap_cnt, 3);
        chk("t4_no_done",  dones,    0);
        step(1, 0, 0, 0, 0, 0);
        chk("t4_rst_wrap", wrap_cnt, 0);

        // Stop at address 4 together with ready.
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        chk("t5_at4", addr_out, 4);
        step(0, 0, 1, 0, 0, 1);
        chk("t5_stop_addr",  addr_out,   4);
        chk("t5_stop_valid", addr_valid, 0);
        chk("t5_stop_done",  done,       0);
        step(0, 0, 0, 0, 0, 0);
        chk("t5_idle_done",  done,       0);
        // start and stop together in IDLE: stay idle.
        step(0, 1, 1, 0, 0, 1);
        chk("t5_ss_valid", addr_valid, 0);
        // Restart from 0; a start while sweeping is ignored.
        step(0, 1, 0, 0, 0, 0);
        chk("t5_restart", addr_out, 0);
        step(0, 1, 0, 0, 0, 1);
        chk("t5_start_in_scan", addr_out, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        chk("t5_at5", addr_out, 5);
        step(1, 0, 0, 0, 0, 1);
        chk("t5_rst_addr",  addr_out,   0);
        chk("t5_rst_valid", addr_valid, 0);
        chk("t5_rst_busy",  busy,       0);
        chk("t5_rst_done",  done,       0);
        step(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_scan_addr_gen
`default_nettype wire
